controller_spi: RTL and testbench

- SPI controller (master) stage directly upstream of the SPI target. Generates SCK, SS and MOSI for one 16-bit full-duplex transaction per start request and shifts in MISO.
- Supports all four CKP/CPH modes and divides the system clock to produce SCK.
- Provides SCK_anterior, the one-CLK-delayed copy of SCK that the target uses for edge detection.

---
 rtl/controller_spi.sv | 146 ++++++++++++++
 tb/tb_controller_spi.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/controller_spi.sv
// controller_spi: SPI master issuing one full-duplex DATA_WIDTH-bit transaction per start,
// all four CKP/CPH modes, SCK half-period of DIV system clocks.
module controller_spi #(
    parameter int DATA_WIDTH = 16,
    parameter int DIV        = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  start,
    input  logic                  CKP,
    input  logic                  CPH,
    input  logic [DATA_WIDTH-1:0] dato_enviar,
    input  logic                  MISO,
    output logic                  SCK,
    output logic                  SCK_anterior,
    output logic                  SS,
    output logic                  MOSI,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] dato_recibido
);
    localparam int EW = $clog2(2*DATA_WIDTH+1);
    localparam int CW = $clog2(DIV+1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2*DATA_WIDTH-1);
    localparam logic [CW-1:0] DIV_END   = CW'(DIV-1);

    typedef enum logic [1:0] {IDLE, SETUP, TRANSFER, HOLD} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         div_cnt_q, div_cnt_d;
    logic [EW-1:0]         edge_cnt_q, edge_cnt_d;
    logic [1:0]            mode_q, mode_d;
    logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_word_q, rx_word_d;
    logic                  sck_q, sck_d, ss_q, ss_d, mosi_q, mosi_d;
    logic                  busy_q, busy_d, done_q, done_d, scka_q;
    logic                  tick, lead;

    assign SCK           = sck_q;
    assign SCK_anterior  = scka_q;
    assign SS            = ss_q;
    assign MOSI          = mosi_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign dato_recibido = rx_word_q;

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        edge_cnt_d = edge_cnt_q;
        mode_d     = mode_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_word_d  = rx_word_q;
        sck_d      = sck_q;
        ss_d       = ss_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tick       = div_cnt_q == DIV_END;
        // toggle number edge_cnt_q+1 is odd, i.e. a leading edge
        lead       = ~edge_cnt_q[0];
        case (state_q)
            IDLE: begin
                sck_d = CKP;
                if (start) begin
                    state_d   = SETUP;
                    mode_d    = {CKP, CPH};
                    tx_sr_d   = dato_enviar;
                    div_cnt_d = '0;
                    ss_d      = 1'b0;
                    busy_d    = 1'b1;
                    mosi_d    = dato_enviar[DATA_WIDTH-1];
                end
            end
            SETUP: begin
                sck_d     = mode_q[1];
                div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
                state_d   = tick ? TRANSFER : SETUP;
            end
            TRANSFER: begin
                div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
                if (tick) begin
                    sck_d      = ~sck_q;
                    edge_cnt_d = edge_cnt_q + 1'b1;
                    // sample edge is leading for CPH=0, trailing for CPH=1; the other edge drives
                    if (lead ^ mode_q[0]) begin
                        rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], MISO};
                    end else if (mode_q[0]) begin
                        mosi_d  = tx_sr_q[DATA_WIDTH-1];
                        tx_sr_d = tx_sr_q << 1;
                    end else if (edge_cnt_q != LAST_EDGE) begin
                        mosi_d  = tx_sr_q[DATA_WIDTH-2];
                        tx_sr_d = tx_sr_q << 1;
                    end
                    if (edge_cnt_q == LAST_EDGE) begin
                        state_d    = HOLD;
                        edge_cnt_d = '0;
                    end
                end
            end
            default: begin
                div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
                if (tick) begin
                    state_d   = IDLE;
                    ss_d      = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_word_d = rx_sr_q;
                    mosi_d    = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            edge_cnt_q <= '0;
            mode_q     <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_word_q  <= '0;
            sck_q      <= 1'b0;
            scka_q     <= 1'b0;
            ss_q       <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            mode_q     <= mode_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_word_q  <= rx_word_d;
            sck_q      <= sck_d;
            scka_q     <= sck_q;
            ss_q       <= ss_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end
endmodule

// File: tb/tb_controller_spi.sv
// tb_controller_spi: directed bench for controller_spi; u0 runs DIV=2 with a bench SPI target,
// u1 runs DIV=1 with MISO tied low.
module tb_controller_spi;
    logic        CLK = 1'b0, RESET = 1'b1, CKP = 1'b0, CPH = 1'b0, miso0 = 1'b0;
    logic [1:0]  st = 2'b00;
    logic [15:0] dato = '0, resp = '0;
    logic [1:0]  sck, scka, ss, mosi, busy, done;
    logic [15:0] rcv [2];

    int tests = 0, fails = 0;

    // target model / monitor state, written only by the monitor process
    logic [1:0]  tmode [2];
    logic [15:0] tsr, mcap [2];
    logic [1:0]  psck = 2'b00;
    logic        mon_lead;
    int          ss_cnt [2], rise_cnt [2], tog_cnt [2], done_cnt [2];
    int          ant_err = 0;

    typedef struct {
        int          u;
        logic        ckp, cph;
        logic [15:0] tx, rsp, rx;
        int          ssn;
    } vec_t;
    vec_t vt [6];

    always #5 CLK = ~CLK;

    controller_spi #(.DATA_WIDTH(16), .DIV(2)) u0 (
        .CLK(CLK), .RESET(RESET), .start(st[0]), .CKP(CKP), .CPH(CPH), .dato_enviar(dato),
        .MISO(miso0), .SCK(sck[0]), .SCK_anterior(scka[0]), .SS(ss[0]), .MOSI(mosi[0]),
        .busy(busy[0]), .done(done[0]), .dato_recibido(rcv[0]));

    controller_spi #(.DATA_WIDTH(16), .DIV(1)) u1 (
        .CLK(CLK), .RESET(RESET), .start(st[1]), .CKP(CKP), .CPH(CPH), .dato_enviar(dato),
        .MISO(1'b0), .SCK(sck[1]), .SCK_anterior(scka[1]), .SS(ss[1]), .MOSI(mosi[1]),
        .busy(busy[1]), .done(done[1]), .dato_recibido(rcv[1]));

    initial begin
        for (int i = 0; i < 2; i++) begin
            tmode[i] = '0; mcap[i] = '0;
            ss_cnt[i] = 0; rise_cnt[i] = 0; tog_cnt[i] = 0; done_cnt[i] = 0;
        end
        tsr = '0;
    end

    // SPI target: presents resp MSB-first, captures MOSI on the sampling edge of the latched mode
    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (i == 1 && scka[1] !== psck[1]) ant_err++;
            if (ss[i]) begin
                tmode[i] = {CKP, CPH};
                if (i == 0) begin tsr = resp; miso0 = resp[15]; end
            end else begin
                ss_cnt[i]++;
                if (sck[i] != psck[i]) begin
                    mon_lead = sck[i] != tmode[i][1];
                    tog_cnt[i]++;
                    if (sck[i]) rise_cnt[i]++;
                    if (mon_lead != tmode[i][0]) mcap[i] = {mcap[i][14:0], mosi[i]};
                    else if (i == 0 && tmode[i][0]) begin miso0 = tsr[15]; tsr = tsr << 1; end
                    else if (i == 0) begin tsr = tsr << 1; miso0 = tsr[15]; end
                end
            end
            if (done[i]) done_cnt[i]++;
            psck[i] = sck[i];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_done(input int i, input string nm);
        int n = 0;
        while (!done[i] && n < 300) begin @(negedge CLK); n++; end
        chk(nm, {31'd0, done[i]}, 32'd1);
    endtask

    task automatic setup_mode(input logic ckp, input logic cph, input logic [15:0] tx,
                              input logic [15:0] rsp);
        @(negedge CLK);
        CKP = ckp; CPH = cph; dato = tx; resp = rsp;
        repeat (2) @(negedge CLK);
    endtask

    task automatic run_txn(input int i, input logic ckp, input logic cph, input logic [15:0] tx,
                           input logic [15:0] rsp, output logic [15:0] rx, output logic [15:0] mc,
                           output int ssn, output int rises, output int dones,
                           output logic sck_pre, output logic sck_post, output logic ss_done);
        int s0, r0, d0;
        setup_mode(ckp, cph, tx, rsp);
        sck_pre = sck[i];
        s0 = ss_cnt[i]; r0 = rise_cnt[i]; d0 = done_cnt[i];
        st[i] = 1'b1;
        @(negedge CLK);
        st[i] = 1'b0;
        wait_done(i, "done_seen");
        rx = rcv[i]; mc = mcap[i]; ss_done = ss[i];
        repeat (3) @(negedge CLK);
        sck_post = sck[i];
        ssn = ss_cnt[i] - s0; rises = rise_cnt[i] - r0; dones = done_cnt[i] - d0;
    endtask

    initial begin
        logic [15:0] rx, mc;
        int ssn, rises, dones, s0, d0, t0, n;
        logic sp, sq, sd;
        vt[0] = '{0, 1'b0, 1'b0, 16'hA5C3, 16'h3C5A, 16'h3C5A, 68};
        vt[1] = '{0, 1'b0, 1'b1, 16'hA5C3, 16'h3C5A, 16'h3C5A, 68};
        vt[2] = '{0, 1'b1, 1'b0, 16'hA5C3, 16'h3C5A, 16'h3C5A, 68};
        vt[3] = '{0, 1'b1, 1'b1, 16'hA5C3, 16'h3C5A, 16'h3C5A, 68};
        vt[4] = '{0, 1'b0, 1'b1, 16'h1234, 16'hFEDC, 16'hFEDC, 68};
        vt[5] = '{1, 1'b0, 1'b0, 16'hFFFF, 16'h3C5A, 16'h0000, 34};

        repeat (3) @(negedge CLK);
        chk("rst_ss", {30'd0, ss}, 32'd3);
        chk("rst_sck", {30'd0, sck}, 32'd0);
        chk("rst_scka", {30'd0, scka}, 32'd0);
        chk("rst_busy_done_mosi", {26'd0, busy, done, mosi}, 32'd0);
        chk("rst_rx", {16'd0, rcv[0]}, 32'd0);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);

        for (int k = 0; k < 6; k++) begin
            run_txn(vt[k].u, vt[k].ckp, vt[k].cph, vt[k].tx, vt[k].rsp, rx, mc, ssn, rises, dones,
                    sp, sq, sd);
            chk($sformatf("v%0d_rx", k), {16'd0, rx}, {16'd0, vt[k].rx});
            chk($sformatf("v%0d_mosi_stream", k), {16'd0, mc}, {16'd0, vt[k].tx});
            chk($sformatf("v%0d_ss_low", k), ssn, vt[k].ssn);
            chk($sformatf("v%0d_sck_rises", k), rises, 32'd16);
            chk($sformatf("v%0d_done_pulses", k), dones, 32'd1);
            chk($sformatf("v%0d_sck_idle_pre", k), {31'd0, sp}, {31'd0, vt[k].ckp});
            chk($sformatf("v%0d_sck_idle_post", k), {31'd0, sq}, {31'd0, vt[k].ckp});
            chk($sformatf("v%0d_ss_at_done", k), {31'd0, sd}, 32'd1);
        end

        // start held through a whole transaction and past done
        setup_mode(1'b0, 1'b0, 16'hA5C3, 16'h3C5A);
        s0 = ss_cnt[0]; d0 = done_cnt[0];
        st[0] = 1'b1;
        @(negedge CLK);
        wait_done(0, "hold_done1_seen");
        chk("hold_ss_at_done", {31'd0, ss[0]}, 32'd1);
        chk("hold_single_txn_ss", ss_cnt[0] - s0, 32'd68);
        chk("hold_rx1", {16'd0, rcv[0]}, 32'h3C5A);
        @(negedge CLK);
        chk("hold_restart_ss", {31'd0, ss[0]}, 32'd0);
        chk("hold_restart_busy", {31'd0, busy[0]}, 32'd1);
        st[0] = 1'b0;
        wait_done(0, "hold_done2_seen");
        chk("hold_rx2", {16'd0, rcv[0]}, 32'h3C5A);
        repeat (3) @(negedge CLK);
        chk("hold_done_pulses", done_cnt[0] - d0, 32'd2);

        // asynchronous reset around toggle 9
        setup_mode(1'b0, 1'b0, 16'hA5C3, 16'h3C5A);
        d0 = done_cnt[0]; t0 = tog_cnt[0];
        st[0] = 1'b1;
        @(negedge CLK);
        st[0] = 1'b0;
        n = 0;
        while (tog_cnt[0] - t0 < 9 && n < 300) begin @(negedge CLK); n++; end
        chk("rst9_reached", tog_cnt[0] - t0, 32'd9);
        RESET = 1'b1;
        #1;
        chk("rst9_ss", {31'd0, ss[0]}, 32'd1);
        chk("rst9_sck", {31'd0, sck[0]}, 32'd0);
        chk("rst9_busy", {31'd0, busy[0]}, 32'd0);
        chk("rst9_rx", {16'd0, rcv[0]}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        repeat (4) @(negedge CLK);
        chk("rst9_no_done", done_cnt[0] - d0, 32'd0);
        chk("rst9_rx_after", {16'd0, rcv[0]}, 32'd0);
        run_txn(0, 1'b0, 1'b0, 16'hA5C3, 16'h3C5A, rx, mc, ssn, rises, dones, sp, sq, sd);
        chk("rst9_next_rx", {16'd0, rx}, 32'h3C5A);
        chk("rst9_next_ss_low", ssn, 32'd68);

        // mode inputs changed mid-transfer: 0 -> 3
        setup_mode(1'b0, 1'b0, 16'hA5C3, 16'h3C5A);
        st[0] = 1'b1;
        @(negedge CLK);
        st[0] = 1'b0;
        repeat (20) @(negedge CLK);
        CKP = 1'b1; CPH = 1'b1; dato = 16'h0F0F;
        wait_done(0, "mchg_done_seen");
        chk("mchg_rx", {16'd0, rcv[0]}, 32'h3C5A);
        chk("mchg_mosi_stream", {16'd0, mcap[0]}, 32'hA5C3);
        repeat (3) @(negedge CLK);
        chk("mchg_idle_new_ckp", {31'd0, sck[0]}, 32'd1);
        run_txn(0, 1'b1, 1'b1, 16'h1234, 16'hFEDC, rx, mc, ssn, rises, dones, sp, sq, sd);
        chk("mchg_next_rx", {16'd0, rx}, 32'hFEDC);
        chk("mchg_next_mosi", {16'd0, mc}, 32'h1234);

        chk("sck_anterior_delay_errs", ant_err, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
